// File: rtl/dir_rom_pkg.sv
// Shared constants, packet-state type and rotation helper for the
// orientation-bin rotator that replaces the per-orientation ROM family.
package dir_rom_pkg;

    localparam int DIR_BIN_W          = 5;
    localparam int DIR_SEL_W          = 4;
    localparam int DIR_OFFSET_DEFAULT = 24;
    localparam int DIR_CALC_W         = 16;

    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_IN   = 1'b1
    } pkt_state_e;

    // Keeps the low sel_w bits of dir, adds offset and wraps modulo 2^bin_w.
    function automatic logic [DIR_CALC_W-1:0] dir_rotate(
        input logic [DIR_CALC_W-1:0] dir,
        input logic [DIR_CALC_W-1:0] offset,
        input int                    sel_w,
        input int                    bin_w
    );
        logic [DIR_CALC_W-1:0] sel;
        logic [DIR_CALC_W-1:0] sum;
        sel = dir;
        for (int b = 0; b < DIR_CALC_W; b++) begin
            if (b >= sel_w) sel[b] = 1'b0;
        end
        sum = sel + offset;
        for (int b = 0; b < DIR_CALC_W; b++) begin
            if (b >= bin_w) sum[b] = 1'b0;
        end
        return sum;
    endfunction

endpackage

// File: rtl/dir_rot_stage.sv
// Generic valid/ready pipeline register: accepts whenever empty or when the
// downstream side is taking the current word, so a full pipe has no bubbles.
module dir_rot_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) data_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/dir_bin_rotator.sv
// Rotates gradient-direction codes into histogram bins with a per-keypoint
// offset; offset changes take effect only at packet boundaries.
module dir_bin_rotator
    import dir_rom_pkg::*;
#(
    parameter int IN_W         = 8,
    parameter int SEL_W        = DIR_SEL_W,
    parameter int BIN_W        = DIR_BIN_W,
    parameter int LANES        = 1,
    parameter int OFFSET_RESET = DIR_OFFSET_DEFAULT,
    parameter int CNT_W        = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    input  logic [BIN_W-1:0]       cfg_offset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [LANES*IN_W-1:0]  s_dir,
    input  logic                   s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [LANES*BIN_W-1:0] m_bin,
    output logic                   m_last,
    output logic [CNT_W-1:0]       pkt_beats,
    output logic                   cfg_pending
);

    localparam int S1_W = 1 + BIN_W + LANES * IN_W;
    localparam int S2_W = 1 + LANES * BIN_W;

    pkt_state_e       state_q, state_d;
    logic [BIN_W-1:0] active_q, active_d;
    logic [BIN_W-1:0] pending_q, pending_d;
    logic             pend_flag_q, pend_flag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic boundary;

    assign accept   = s_valid && s_ready;
    assign boundary = (state_q == PKT_IDLE) || (accept && s_last);

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        cnt_d       = cnt_q;

        if (accept) begin
            state_d = s_last ? PKT_IDLE : PKT_IN;
            if (s_last) begin
                cnt_d = '0;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A write landing on a boundary bypasses pending entirely.
        if (boundary) begin
            if (cfg_valid) begin
                active_d  = cfg_offset;
                pending_d = cfg_offset;
            end else if (pend_flag_q) begin
                active_d = pending_q;
            end
            pend_flag_d = 1'b0;
        end else if (cfg_valid) begin
            pending_d   = cfg_offset;
            pend_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PKT_IDLE;
            active_q    <= BIN_W'(OFFSET_RESET);
            pending_q   <= '0;
            pend_flag_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_flag_q <= pend_flag_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pkt_beats   = cnt_q;
    assign cfg_pending = pend_flag_q;

    // Each beat carries the offset sampled at acceptance so later loads
    // never disturb beats already in flight.
    logic                   s1_valid, s1_ready, s2_ready;
    logic [S1_W-1:0]        s1_in, s1_out;
    logic [S2_W-1:0]        s2_in, s2_out;
    logic                   s1_last;
    logic [BIN_W-1:0]       s1_off;
    logic [LANES*IN_W-1:0]  s1_dir;
    logic [LANES*BIN_W-1:0] s2_bins;

    assign s1_in = {s_last, active_q, s_dir};
    assign {s1_last, s1_off, s1_dir} = s1_out;

    dir_rot_stage #(.W(S1_W)) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_valid),
        .in_ready  (s1_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_out)
    );

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign s2_bins[gi*BIN_W +: BIN_W] = BIN_W'(dir_rotate(
            DIR_CALC_W'(s1_dir[gi*IN_W +: IN_W]),
            DIR_CALC_W'(s1_off),
            SEL_W,
            BIN_W));
    end

    assign s2_in = {s1_last, s2_bins};

    dir_rot_stage #(.W(S2_W)) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (s2_out)
    );

    assign {m_last, m_bin} = s2_out;
    assign s_ready         = s1_ready;

endmodule

// File: tb/tb_dir_bin_rotator.sv
// Scoreboard bench for dir_bin_rotator: single-lane instance for the main
// scenarios plus a four-lane instance for lane packing and wrap.
module tb_dir_bin_rotator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        cfg_valid, s_valid, s_ready, s_last, m_valid, m_ready, m_last, cfg_pending;
    logic [4:0]  cfg_offset, m_bin;
    logic [7:0]  s_dir, pkt_beats;

    logic        cfg_valid4, s_valid4, s_ready4, s_last4, m_valid4, m_ready4, m_last4, cfg_pending4;
    logic [4:0]  cfg_offset4;
    logic [31:0] s_dir4;
    logic [19:0] m_bin4;
    logic [7:0]  pkt_beats4;

    dir_bin_rotator #(.LANES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_offset(cfg_offset),
        .s_valid(s_valid), .s_ready(s_ready), .s_dir(s_dir), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_bin(m_bin), .m_last(m_last),
        .pkt_beats(pkt_beats), .cfg_pending(cfg_pending)
    );

    dir_bin_rotator #(.LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid4), .cfg_offset(cfg_offset4),
        .s_valid(s_valid4), .s_ready(s_ready4), .s_dir(s_dir4), .s_last(s_last4),
        .m_valid(m_valid4), .m_ready(m_ready4), .m_bin(m_bin4), .m_last(m_last4),
        .pkt_beats(pkt_beats4), .cfg_pending(cfg_pending4)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] dir;
        logic [4:0] bin;
        logic       last;
        int         edge_n;
    } sb_t;

    sb_t        sb_q[$];
    sb_t        mon_e;
    logic [4:0] got_bin [256];
    int         n_out = 0;
    logic       chk_lat = 1'b0;
    logic       stall_q = 1'b0;
    logic [4:0] stall_bin;
    logic       stall_last;

    // Output monitor: pops the scoreboard on every output handshake and
    // checks that a stalled output word does not move.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                checks++;
                if (m_valid !== 1'b1 || m_bin !== stall_bin || m_last !== stall_last) begin
                    errors++;
                    $display("FAIL hold: got v=%b bin=%h last=%b want v=1 bin=%h last=%b",
                             m_valid, m_bin, m_last, stall_bin, stall_last);
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got bin=%h want no output", m_bin);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (m_bin !== mon_e.bin || m_last !== mon_e.last) begin
                        errors++;
                        $display("FAIL sb_data dir=%h: got bin=%h last=%b want bin=%h last=%b",
                                 mon_e.dir, m_bin, m_last, mon_e.bin, mon_e.last);
                    end
                    got_bin[mon_e.dir] = m_bin;
                    n_out++;
                    if (chk_lat) begin
                        checks++;
                        if (cyc != mon_e.edge_n + 2) begin
                            errors++;
                            $display("FAIL latency dir=%h: got %0d cycles want 2",
                                     mon_e.dir, cyc - mon_e.edge_n);
                        end
                    end
                end
            end
            stall_q    = m_valid && !m_ready;
            stall_bin  = m_bin;
            stall_last = m_last;
        end
    end

    task automatic tick(input logic [4:0] ebin, output logic acc, output logic rdy);
        @(negedge clk);
        rdy = s_ready;
        acc = s_valid && s_ready;
        if (acc) sb_q.push_back('{dir: s_dir, bin: ebin, last: s_last, edge_n: cyc});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        s_valid   = 1'b0;
        cfg_valid = 1'b0;
        while (sb_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d beats outstanding want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        cfg_valid = 0; cfg_offset = 0; s_valid = 0; s_dir = 0; s_last = 0; m_ready = 1;
        cfg_valid4 = 0; cfg_offset4 = 0; s_valid4 = 0; s_dir4 = 0; s_last4 = 0; m_ready4 = 1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_last !== 1'b0 || m_bin !== 5'h00) begin
            errors++;
            $display("FAIL reset_out: got v=%b last=%b bin=%h want 0 0 00", m_valid, m_last, m_bin);
        end
        checks++;
        if (pkt_beats !== 8'h00 || cfg_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: got beats=%0d pend=%b want 0 0", pkt_beats, cfg_pending);
        end
        checks++;
        if (m_valid4 !== 1'b0 || m_bin4 !== 20'h0) begin
            errors++;
            $display("FAIL reset_out4: got v=%b bin=%h want 0 00000", m_valid4, m_bin4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", s_ready);
        end
    endtask

    task automatic test_legacy();
        logic acc, rdy;
        int   d = 0;
        int   guard = 0;
        int   tdir [6] = '{0, 7, 8, 15, 248, 255};
        logic [4:0] tbin [6] = '{5'h18, 5'h1F, 5'h00, 5'h07, 5'h00, 5'h07};
        chk_lat = 1'b1;
        m_ready = 1'b1;
        while (d < 256 && guard < 1000) begin
            s_valid = 1'b1;
            s_dir   = 8'(d);
            s_last  = (d == 255);
            if (d == 255 && guard < 256) begin
                checks++;
                if (pkt_beats !== 8'hFF) begin
                    errors++;
                    $display("FAIL legacy_count: got %0d want 255", pkt_beats);
                end
            end
            tick(5'((d % 16 + 24) % 32), acc, rdy);
            if (acc) d++;
            guard++;
        end
        checks++;
        if (d != 256) begin
            errors++;
            $display("FAIL legacy_accept: got %0d beats want 256", d);
        end
        drain();
        chk_lat = 1'b0;
        checks++;
        if (pkt_beats !== 8'h00) begin
            errors++;
            $display("FAIL legacy_count_end: got %0d want 0", pkt_beats);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_bin[tdir[i]] !== tbin[i]) begin
                errors++;
                $display("FAIL legacy_table dir=%h: got %h want %h", tdir[i], got_bin[tdir[i]], tbin[i]);
            end
        end
    endtask

    task automatic test_deferred();
        logic acc, rdy;
        logic       sv [5] = '{1, 0, 1, 1, 1};
        logic       sl [5] = '{0, 0, 0, 1, 1};
        logic       cv [5] = '{0, 1, 0, 0, 0};
        logic [4:0] eb [5] = '{5'h06, 5'h00, 5'h06, 5'h06, 5'h11};
        logic       ep [5] = '{0, 1, 1, 0, 0};
        logic [7:0] ec [5] = '{8'd1, 8'd1, 8'd2, 8'd0, 8'd0};
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_valid = sv[i]; s_dir = 8'h0E; s_last = sl[i];
            cfg_valid = cv[i]; cfg_offset = 5'd3;
            tick(eb[i], acc, rdy);
            checks++;
            if (acc !== sv[i]) begin
                errors++;
                $display("FAIL deferred_accept step %0d: got %b want %b", i, acc, sv[i]);
            end
            checks++;
            if (cfg_pending !== ep[i]) begin
                errors++;
                $display("FAIL deferred_pending step %0d: got %b want %b", i, cfg_pending, ep[i]);
            end
            checks++;
            if (pkt_beats !== ec[i]) begin
                errors++;
                $display("FAIL deferred_count step %0d: got %0d want %0d", i, pkt_beats, ec[i]);
            end
        end
        drain();
    endtask

    task automatic test_simultaneous();
        logic acc, rdy;
        logic       sl [3] = '{0, 1, 1};
        logic       cv [3] = '{0, 1, 0};
        logic [4:0] eb [3] = '{5'h05, 5'h05, 5'h0B};
        logic [7:0] ec [3] = '{8'd1, 8'd0, 8'd0};
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_dir = 8'h02; s_last = sl[i];
            cfg_valid = cv[i]; cfg_offset = 5'd9;
            tick(eb[i], acc, rdy);
            checks++;
            if (cfg_pending !== 1'b0) begin
                errors++;
                $display("FAIL simul_pending step %0d: got %b want 0", i, cfg_pending);
            end
            checks++;
            if (pkt_beats !== ec[i]) begin
                errors++;
                $display("FAIL simul_count step %0d: got %0d want %0d", i, pkt_beats, ec[i]);
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic acc, rdy;
        int   sent = 0;
        int   n0 = n_out;
        for (int c = 0; c < 12; c++) begin
            m_ready = !(c >= 2 && c <= 5);
            s_valid = (sent < 6);
            s_dir   = 8'(8'h30 + sent);
            s_last  = (sent == 5);
            tick(5'(9 + sent), acc, rdy);
            checks++;
            if (rdy !== !(c >= 2 && c <= 5)) begin
                errors++;
                $display("FAIL bp_ready cycle %0d: got %b want %b", c, rdy, !(c >= 2 && c <= 5));
            end
            if (acc) sent++;
        end
        m_ready = 1'b1;
        checks++;
        if (sent != 6) begin
            errors++;
            $display("FAIL bp_accept: got %0d beats want 6", sent);
        end
        drain();
        checks++;
        if (n_out - n0 != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs want 6", n_out - n0);
        end
    endtask

    task automatic test_lanes4();
        int k;
        int n = 0;
        m_ready4 = 1'b1;
        cfg_valid4 = 1'b1; cfg_offset4 = 5'd31;
        @(posedge clk);
        #1;
        cfg_valid4 = 1'b0;
        s_valid4 = 1'b1; s_dir4 = {8'h0F, 8'h01, 8'h00, 8'h10}; s_last4 = 1'b1;
        k = cyc;
        checks++;
        if (s_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL lanes4_ready: got %b want 1", s_ready4);
        end
        @(posedge clk);
        #1;
        s_valid4 = 1'b0;
        while (m_valid4 !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (m_valid4 !== 1'b1) begin
            errors++;
            $display("FAIL lanes4_timeout: got no output want m_valid");
        end
        checks++;
        if (m_bin4 !== {5'h0E, 5'h00, 5'h1F, 5'h1F} || m_last4 !== 1'b1) begin
            errors++;
            $display("FAIL lanes4_bins: got %h last=%b want %h last=1", m_bin4, m_last4,
                     {5'h0E, 5'h00, 5'h1F, 5'h1F});
        end
        checks++;
        if (cyc - k != 2) begin
            errors++;
            $display("FAIL lanes4_latency: got %0d want 2", cyc - k);
        end
    endtask

    task automatic test_reset_mid();
        logic acc, rdy;
        int   sent = 0;
        int   guard = 0;
        m_ready = 1'b1;
        while (sent < 200 && guard < 400) begin
            s_valid = 1'b1; s_dir = 8'(sent); s_last = 1'b0;
            cfg_valid = (sent == 100); cfg_offset = 5'h11;
            tick(5'((sent % 16 + 9) % 32), acc, rdy);
            if (acc) sent++;
            guard++;
        end
        s_valid = 1'b0; cfg_valid = 1'b0;
        checks++;
        if (pkt_beats !== 8'd200 || cfg_pending !== 1'b1 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got beats=%0d pend=%b v=%b want 200 1 1", pkt_beats, cfg_pending, m_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_bin !== 5'h00 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_out: got v=%b bin=%h last=%b want 0 00 0", m_valid, m_bin, m_last);
        end
        checks++;
        if (pkt_beats !== 8'h00 || cfg_pending !== 1'b0) begin
            errors++;
            $display("FAIL mid_ctl: got beats=%0d pend=%b want 0 0", pkt_beats, cfg_pending);
        end
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b1; s_dir = 8'h05; s_last = 1'b0;
        tick(5'h1D, acc, rdy);
        checks++;
        if (acc !== 1'b1 || pkt_beats !== 8'd1) begin
            errors++;
            $display("FAIL mid_first: got acc=%b beats=%0d want 1 1", acc, pkt_beats);
        end
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_legacy();
        test_deferred();
        test_simultaneous();
        test_backpressure();
        test_lanes4();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
